// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register index type and
// the architectural register conventions used by the decode stage.
package y86_pkg;

    typedef logic [3:0] reg_idx_t;

    localparam reg_idx_t RNONE       = 4'hF;
    localparam int       RSP_DEFAULT = 4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

endpackage

// File: rtl/regfile_2r2w.sv
// NREG x WIDTH register file, two combinational reads and two writes (M beats E).
// Same-cycle write-to-read bypass is built only when DECODE_BYPASS_EN is defined.
module regfile_2r2w
    import y86_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int NREG  = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       raddr_a,
    input  logic [3:0]       raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    input  logic [3:0]       waddr_e,
    input  logic [WIDTH-1:0] wdata_e,
    input  logic [3:0]       waddr_m,
    input  logic [WIDTH-1:0] wdata_m
);

    logic [WIDTH-1:0] regs [NREG];

    // Indices >= NREG (including RNONE) never match a storage slot, so
    // out-of-range writes fall away without an explicit range check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (waddr_m == reg_idx_t'(i))      regs[i] <= wdata_m;
                else if (waddr_e == reg_idx_t'(i)) regs[i] <= wdata_e;
            end
        end
    end

    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        for (int i = 0; i < NREG; i++) begin
            if (raddr_a == reg_idx_t'(i)) rdata_a = regs[i];
            if (raddr_b == reg_idx_t'(i)) rdata_b = regs[i];
        end
`ifdef DECODE_BYPASS_EN
        if (int'(raddr_a) < NREG) begin
            if (raddr_a == waddr_m)      rdata_a = wdata_m;
            else if (raddr_a == waddr_e) rdata_a = wdata_e;
        end
        if (int'(raddr_b) < NREG) begin
            if (raddr_b == waddr_m)      rdata_b = wdata_m;
            else if (raddr_b == waddr_e) rdata_b = wdata_e;
        end
`endif
    end

endmodule

// File: rtl/decode_rf.sv
// Y86-64 decode stage: source selection, register file and output register.
// Optional same-cycle writeback bypass is enabled by defining DECODE_BYPASS_EN.
module decode_rf
    import y86_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int NREG    = 15,
    parameter int RSP_IDX = RSP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       icode,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic             stall,
    input  logic             bubble,
    input  logic [3:0]       dstE,
    input  logic [WIDTH-1:0] valE,
    input  logic [3:0]       dstM,
    input  logic [WIDTH-1:0] valM,
    output logic             out_valid,
    output logic [3:0]       srcA,
    output logic [3:0]       srcB,
    output logic [WIDTH-1:0] valA,
    output logic [WIDTH-1:0] valB
);

    localparam reg_idx_t RSP = reg_idx_t'(RSP_IDX);

    logic [3:0]       sel_a;
    logic [3:0]       sel_b;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;

    always_comb begin
        sel_a = RNONE;
        sel_b = RNONE;
        case (icode)
            I_RRMOVQ:        sel_a = rA;
            I_IRMOVQ:        sel_b = rB;
            I_RMMOVQ, I_OPQ: begin sel_a = rA;  sel_b = rB;  end
            I_MRMOVQ:        sel_b = rB;
            I_CALL:          sel_b = RSP;
            I_RET, I_POPQ:   begin sel_a = RSP; sel_b = RSP; end
            I_PUSHQ:         begin sel_a = rA;  sel_b = RSP; end
            default:         ;
        endcase
    end

    regfile_2r2w #(.WIDTH(WIDTH), .NREG(NREG)) u_rf (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (sel_a),
        .raddr_b (sel_b),
        .rdata_a (rd_a),
        .rdata_b (rd_b),
        .waddr_e (dstE),
        .wdata_e (valE),
        .waddr_m (dstM),
        .wdata_m (valM)
    );

    // Flow control: a transfer is accepted when in_valid is high and stall is
    // low; stall freezes the output register (acting as backpressure) and
    // bubble or !in_valid loads a nop with out_valid low. Writeback ignores both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            srcA      <= RNONE;
            srcB      <= RNONE;
            valA      <= '0;
            valB      <= '0;
        end else if (!stall) begin
            if (bubble || !in_valid) begin
                out_valid <= 1'b0;
                srcA      <= RNONE;
                srcB      <= RNONE;
                valA      <= '0;
                valB      <= '0;
            end else begin
                out_valid <= 1'b1;
                srcA      <= sel_a;
                srcB      <= sel_b;
                valA      <= rd_a;
                valB      <= rd_b;
            end
        end
    end

endmodule

// File: tb/tb_decode_rf.sv
// Self-checking bench for decode_rf: directed test-plan steps plus random traffic,
// checked against an array-based register model (NREG=15 and NREG=14 instances).
module tb_decode_rf;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  icode;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic        stall;
    logic        bubble;
    logic [3:0]  dstE;
    logic [63:0] valE;
    logic [3:0]  dstM;
    logic [63:0] valM;

    logic        ov0, ov1;
    logic [3:0]  sa0, sb0, sa1, sb1;
    logic [63:0] va0, vb0, va1, vb1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_rf #(.WIDTH(64), .NREG(15), .RSP_IDX(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .icode(icode), .rA(rA), .rB(rB),
        .stall(stall), .bubble(bubble), .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
        .out_valid(ov0), .srcA(sa0), .srcB(sb0), .valA(va0), .valB(vb0)
    );

    decode_rf #(.WIDTH(64), .NREG(14), .RSP_IDX(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .icode(icode), .rA(rA), .rB(rB),
        .stall(stall), .bubble(bubble), .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
        .out_valid(ov1), .srcA(sa1), .srcB(sb1), .valA(va1), .valB(vb1)
    );

    // Reference model: register arrays, operand-usage table, expected outputs.
    int          nreg [2] = '{15, 14};
    logic [63:0] mreg [2][15];
    int          use_a [16];
    int          use_b [16];
    logic        e_valid [2];
    logic [3:0]  e_srcA  [2];
    logic [3:0]  e_srcB  [2];
    logic [63:0] e_valA  [2];
    logic [63:0] e_valB  [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // 0: none, 1: rA, 2: rB, 3: stack pointer
    function automatic logic [3:0] pick(int s);
        case (s)
            1:       return rA;
            2:       return rB;
            3:       return 4'd4;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [63:0] mread(int k, logic [3:0] idx);
        if (int'(idx) >= nreg[k]) return 64'd0;
`ifdef DECODE_BYPASS_EN
        if (idx == dstM) return valM;
        if (idx == dstE) return valE;
`endif
        return mreg[k][idx];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 15; i++) mreg[k][i] = 64'd0;
            e_valid[k] = 1'b0;
            e_srcA[k]  = 4'hF;
            e_srcB[k]  = 4'hF;
            e_valA[k]  = 64'd0;
            e_valB[k]  = 64'd0;
        end
    endtask

    task automatic compare_all();
        chk("out_valid0", {63'd0, ov0}, {63'd0, e_valid[0]});
        chk("srcA0", {60'd0, sa0}, {60'd0, e_srcA[0]});
        chk("srcB0", {60'd0, sb0}, {60'd0, e_srcB[0]});
        chk("valA0", va0, e_valA[0]);
        chk("valB0", vb0, e_valB[0]);
        chk("out_valid1", {63'd0, ov1}, {63'd0, e_valid[1]});
        chk("srcA1", {60'd0, sa1}, {60'd0, e_srcA[1]});
        chk("srcB1", {60'd0, sb1}, {60'd0, e_srcB[1]});
        chk("valA1", va1, e_valA[1]);
        chk("valB1", vb1, e_valB[1]);
    endtask

    // Predict the edge from current inputs, let it happen, then compare.
    task automatic tick();
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!stall) begin
                    if (bubble || !in_valid) begin
                        e_valid[k] = 1'b0;
                        e_srcA[k]  = 4'hF;
                        e_srcB[k]  = 4'hF;
                        e_valA[k]  = 64'd0;
                        e_valB[k]  = 64'd0;
                    end else begin
                        e_valid[k] = 1'b1;
                        e_srcA[k]  = pick(use_a[icode]);
                        e_srcB[k]  = pick(use_b[icode]);
                        e_valA[k]  = mread(k, e_srcA[k]);
                        e_valB[k]  = mread(k, e_srcB[k]);
                    end
                end
                if (int'(dstE) < nreg[k]) mreg[k][dstE] = valE;
                if (int'(dstM) < nreg[k]) mreg[k][dstM] = valM;
            end
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] a,
                         input logic [3:0] b);
        in_valid = v;
        icode    = ic;
        rA       = a;
        rB       = b;
    endtask

    task automatic wr(input logic [3:0] de, input logic [63:0] ve,
                      input logic [3:0] dm, input logic [63:0] vm);
        dstE = de;
        valE = ve;
        dstM = dm;
        valM = vm;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            use_a[i] = 0;
            use_b[i] = 0;
        end
        use_a[2]  = 1;
        use_b[3]  = 2;
        use_a[4]  = 1; use_b[4]  = 2;
        use_b[5]  = 2;
        use_a[6]  = 1; use_b[6]  = 2;
        use_b[8]  = 3;
        use_a[9]  = 3; use_b[9]  = 3;
        use_a[10] = 1; use_b[10] = 3;
        use_a[11] = 3; use_b[11] = 3;

        // Reset with writes presented: writes must be dropped.
        rst = 1'b1;
        stall = 1'b0;
        bubble = 1'b0;
        drive(1'b1, 4'h6, 4'h1, 4'h2);
        wr(4'd1, 64'hAAAA, 4'd2, 64'hBBBB);
        model_reset();
        #1;
        compare_all();
        tick();
        tick();
        rst = 1'b0;
        wr(4'hF, 64'd0, 4'hF, 64'd0);

        // Every register reads back 0 after reset.
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 4'h6, 4'(i), 4'(i));
            tick();
            chk("reset_readback", va0, 64'd0);
        end

        // E write then OPq reads it the following cycle.
        drive(1'b0, 4'h1, 4'h0, 4'h0);
        wr(4'd3, 64'h1234, 4'hF, 64'd0);
        tick();
        wr(4'hF, 64'd0, 4'hF, 64'd0);
        drive(1'b1, 4'h6, 4'd3, 4'd3);
        tick();
        chk("opq_valA", va0, 64'h1234);
        chk("opq_valB", vb0, 64'h1234);

        // Same-edge E/M to the same register: M wins.
        drive(1'b0, 4'h1, 4'h0, 4'h0);
        wr(4'd4, 64'h100, 4'd4, 64'h200);
        tick();
        wr(4'hF, 64'd0, 4'hF, 64'd0);
        drive(1'b1, 4'h9, 4'hF, 4'hF);
        tick();
        chk("ret_valA", va0, 64'h200);
        chk("ret_valB", vb0, 64'h200);

        // pushq, then stall twice with new inputs, then bubble.
        drive(1'b0, 4'h1, 4'h0, 4'h0);
        wr(4'd0, 64'h5, 4'd4, 64'h80);
        tick();
        wr(4'hF, 64'd0, 4'hF, 64'd0);
        drive(1'b1, 4'hA, 4'd0, 4'hF);
        tick();
        chk("push_srcA", {60'd0, sa0}, 64'd0);
        chk("push_srcB", {60'd0, sb0}, 64'd4);
        chk("push_valA", va0, 64'h5);
        chk("push_valB", vb0, 64'h80);
        stall = 1'b1;
        drive(1'b1, 4'h6, 4'd7, 4'd8);
        wr(4'd9, 64'h999, 4'hF, 64'd0);
        tick();
        drive(1'b1, 4'h2, 4'd9, 4'd1);
        bubble = 1'b1;
        tick();
        chk("stall_valA", va0, 64'h5);
        chk("stall_valB", vb0, 64'h80);
        chk("stall_valid", {63'd0, ov0}, 64'd1);
        stall = 1'b0;
        wr(4'hF, 64'd0, 4'hF, 64'd0);
        tick();
        chk("bubble_valid", {63'd0, ov0}, 64'd0);
        bubble = 1'b0;
        drive(1'b1, 4'h2, 4'd9, 4'hF);
        tick();
        chk("write_during_stall", va0, 64'h999);

        // Same-cycle write and read of R2.
        drive(1'b0, 4'h1, 4'h0, 4'h0);
        wr(4'd2, 64'h11, 4'hF, 64'd0);
        tick();
        drive(1'b1, 4'h4, 4'd2, 4'd1);
        wr(4'd2, 64'h77, 4'hF, 64'd0);
        tick();
`ifdef DECODE_BYPASS_EN
        chk("same_cycle_r2", va0, 64'h77);
`else
        chk("same_cycle_r2", va0, 64'h11);
`endif
        wr(4'hF, 64'd0, 4'hF, 64'd0);
        tick();
        chk("after_write_r2", va0, 64'h77);

        // rA=F reads 0; index 14 is storage only in the NREG=15 instance.
        drive(1'b1, 4'h6, 4'hF, 4'd0);
        wr(4'd14, 64'hDEAD, 4'hF, 64'd0);
        tick();
        chk("rnone_valA", va1, 64'd0);
        wr(4'hF, 64'd0, 4'hF, 64'd0);
        drive(1'b1, 4'h2, 4'd14, 4'hF);
        tick();
        chk("r14_nreg15", va0, 64'hDEAD);
        chk("r14_nreg14", va1, 64'd0);
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, 4'h6, 4'(i), 4'(i));
            tick();
        end

        // Asynchronous reset mid-operation, no clock edge needed.
        drive(1'b1, 4'h6, 4'd3, 4'd4);
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        wr(4'd5, 64'h55, 4'd6, 64'h66);
        tick();
        rst = 1'b0;
        wr(4'hF, 64'd0, 4'hF, 64'd0);
        drive(1'b1, 4'h6, 4'd5, 4'd6);
        tick();
        chk("post_reset_r5", va0, 64'd0);
        chk("post_reset_r6", vb0, 64'd0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 9) != 0), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            stall  = ($urandom_range(0, 9) == 0);
            bubble = ($urandom_range(0, 9) == 0);
            wr(4'($urandom_range(0, 15)), {$urandom, $urandom},
               4'($urandom_range(0, 15)), {$urandom, $urandom});
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
